mult_div_ctrl: RTL and testbench

Sequential signed multiply/divide controller that owns the HI/LO register pair of the multicycle CPU. The control unit requests an operation with a one-cycle start pulse. The block then runs a 32-step radix-2 Booth multiply or a 32-step restoring divide, holding `busy` so the control unit stalls. When the operation finishes, it writes HI/LO and pulses `done`. MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/mult_div_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mult_div_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl
// Sequential signed multiply/divide unit that owns the CPU's HI/LO pair.
// A one-cycle start pulse launches either a 32-step radix-2 Booth multiply
// or a 32-step restoring divide on operand magnitudes. While the operation
// runs, busy stays high. On completion HI/LO are written and done pulses.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   mult_start : one-cycle request for signed a*b
//   div_start  : one-cycle request for signed a/b (loses to mult_start)
//   a, b       : 32-bit operands, sampled only on the accepting edge
//   busy       : high while an operation is in progress
//   done       : one-cycle completion pulse, HI/LO updated on same edge
//   div_zero   : high together with done when a divide had b == 0
//   hi, lo     : HI/LO registers (MFHI/MFLO read these directly)

module mult_div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MULT = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Working registers are shared between the two algorithms:
  //   MULT: acc = Booth accumulator, q = multiplier, q1 = Booth extra bit,
  //         m = sign-extended multiplicand.
  //   DIV : before the first step q holds raw a and m holds raw b (with
  //         b's sign bit duplicated); afterwards acc[31:0] is the partial
  //         remainder, q the quotient and m[31:0] the divisor magnitude.
  logic [2:0]  state_q,    state_d;
  logic [5:0]  cnt_q,      cnt_d;
  logic [32:0] acc_q,      acc_d;
  logic [31:0] q_q,        q_d;
  logic        q1_q,       q1_d;
  logic [32:0] m_q,        m_d;
  logic        signQuo_q,  signQuo_d;
  logic        signRem_q,  signRem_d;
  logic [31:0] hi_q,       hi_d;
  logic [31:0] lo_q,       lo_d;
  logic        done_q,     done_d;
  logic        divZero_q,  divZero_d;

  // Booth step datapath: add or subtract M according to {q[0], q_1}.
  logic [32:0] boothSum;

  always_comb begin
    boothSum = acc_q;
    if (q_q[0] && !q1_q) begin
      boothSum = acc_q - m_q;
    end else if (!q_q[0] && q1_q) begin
      boothSum = acc_q + m_q;
    end
  end

  // Restoring-divide step datapath. On the very first DIV edge the step is
  // fed with the freshly computed magnitudes instead of the stored state,
  // so the first step overlaps with operand preparation.
  logic        divFirst;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [31:0] remIn;
  logic [31:0] quoIn;
  logic [31:0] divisor;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] remNext;
  logic [31:0] quoNext;

  always_comb begin
    divFirst = (cnt_q == 6'd0);
    aMag     = q_q[31] ? (~q_q + 32'd1) : q_q;
    bMag     = m_q[31] ? (~m_q[31:0] + 32'd1) : m_q[31:0];
    remIn    = divFirst ? 32'd0 : acc_q[31:0];
    quoIn    = divFirst ? aMag  : q_q;
    divisor  = divFirst ? bMag  : m_q[31:0];
    shifted  = {remIn, quoIn[31]};
    trial    = shifted - {1'b0, divisor};
    remNext  = trial[32] ? shifted[31:0] : trial[31:0];
    quoNext  = {quoIn[30:0], ~trial[32]};
  end

  // Next-state logic for the controller and all working registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    signQuo_d = signQuo_q;
    signRem_d = signRem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divZero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mult_start) begin
          state_d = S_MULT;
          cnt_d   = 6'd0;
          acc_d   = 33'd0;
          q_d     = b;
          q1_d    = 1'b0;
          m_d     = {a[31], a};
        end else if (div_start) begin
          state_d = S_DIV;
          cnt_d   = 6'd0;
          q_d     = a;
          m_d     = {b[31], b};
        end
      end

      S_MULT: begin
        if (cnt_q == 6'd32) begin
          hi_d    = acc_q[31:0];
          lo_d    = q_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d = {boothSum[32], boothSum[32:1]};
          q_d   = {boothSum[0], q_q[31:1]};
          q1_d  = q_q[0];
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_DIV: begin
        if (cnt_q == 6'd32) begin
          state_d = S_FIX;
        end else if (divFirst && (m_q[31:0] == 32'd0)) begin
          done_d    = 1'b1;
          divZero_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          if (divFirst) begin
            signQuo_d = q_q[31] ^ m_q[31];
            signRem_d = q_q[31];
            m_d       = {1'b0, bMag};
          end
          acc_d = {1'b0, remNext};
          q_d   = quoNext;
          cnt_d = cnt_q + 6'd1;
        end
      end

      // Remainder follows the dividend's sign; 0x80000000 / -1 wraps.
      S_FIX: begin
        lo_d    = signQuo_q ? (~q_q + 32'd1) : q_q;
        hi_d    = signRem_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 33'd0;
      q_q       <= 32'd0;
      q1_q      <= 1'b0;
      m_q       <= 33'd0;
      signQuo_q <= 1'b0;
      signRem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      signQuo_q <= signQuo_d;
      signRem_q <= signRem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divZero_q <= divZero_d;
    end
  end

  assign busy     = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done     = done_q;
  assign div_zero = divZero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Testbench for mult_div_ctrl: directed corner cases from the block's
// behaviour plus randomized multiplies/divides, all compared against a
// plain-arithmetic reference model (64-bit signed multiply, truncating
// signed divide and remainder).

module tb_mult_div_ctrl;

  logic        clk;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int passCount;
  int checkCount;

  logic [31:0] modelHi;
  logic [31:0] modelLo;

  mult_div_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and on mismatch reports tag/observed/expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Launch one operation, optionally pulse div_start while busy, wait for
  // done with a cycle budget, and compare everything to the reference model.
  task automatic applyStimulus(input bit doMult, input bit doDiv,
                               input logic [31:0] opA, input logic [31:0] opB,
                               input int injectAt, input string tag);
    int          cycles;
    int          expLat;
    bit          seenDone;
    bit          busyOk;
    bit          expDz;
    logic [31:0] expHi;
    logic [31:0] expLo;
    longint      sa;
    longint      sb;
    longint      prod;
    longint      quo;
    longint      rem;

    sa = longint'($signed(opA));
    sb = longint'($signed(opB));
    expDz = 1'b0;
    if (doMult) begin
      prod   = sa * sb;
      expHi  = prod[63:32];
      expLo  = prod[31:0];
      expLat = 33;
    end else if (opB == 32'd0) begin
      expHi  = modelHi;
      expLo  = modelLo;
      expDz  = 1'b1;
      expLat = 1;
    end else begin
      quo    = sa / sb;
      rem    = sa % sb;
      expLo  = quo[31:0];
      expHi  = rem[31:0];
      expLat = 34;
    end

    @(negedge clk);
    a          = opA;
    b          = opB;
    mult_start = doMult;
    div_start  = doDiv;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = $urandom;
    b          = $urandom;

    cycles   = 0;
    seenDone = 1'b0;
    busyOk   = 1'b1;
    while (!seenDone && cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
      div_start = (cycles == injectAt);
      if (done) seenDone = 1'b1;
      else if (!busy) busyOk = 1'b0;
    end
    div_start = 1'b0;

    checkOutput({tag, "_latency"}, 64'(cycles), 64'(expLat));
    checkOutput({tag, "_busy_run"}, 64'(busyOk), 64'd1);
    checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
    checkOutput({tag, "_div_zero"}, 64'(div_zero), 64'(expDz));

    @(posedge clk);
    #1;
    checkOutput({tag, "_done_drop"}, 64'(done), 64'd0);
    checkOutput({tag, "_dz_drop"}, 64'(div_zero), 64'd0);
    modelHi = expHi;
    modelLo = expLo;
  endtask

  initial begin
    logic [31:0] rA;
    logic [31:0] rB;
    bit          doneSeen;

    passCount  = 0;
    checkCount = 0;
    modelHi    = 32'd0;
    modelLo    = 32'd0;
    reset      = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = 32'd0;
    b          = 32'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_div_zero", 64'(div_zero), 64'd0);

    // Directed multiplies.
    applyStimulus(1'b1, 1'b0, 32'hFFFFFFFD, 32'd7, 0, "mult_basic");
    checkOutput("mult_basic_hi_const", 64'(hi), 64'hFFFFFFFF);
    checkOutput("mult_basic_lo_const", 64'(lo), 64'hFFFFFFEB);
    applyStimulus(1'b1, 1'b0, 32'h80000000, 32'h80000000, 0, "mult_minmin");
    checkOutput("mult_minmin_hi_const", 64'(hi), 64'h40000000);
    checkOutput("mult_minmin_lo_const", 64'(lo), 64'h00000000);
    applyStimulus(1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, "mult_maxmax");
    checkOutput("mult_maxmax_hi_const", 64'(hi), 64'h3FFFFFFF);
    checkOutput("mult_maxmax_lo_const", 64'(lo), 64'h00000001);

    // Directed divides.
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 0, "div_signed");
    checkOutput("div_signed_lo_const", 64'(lo), 64'hFFFFFFFD);
    checkOutput("div_signed_hi_const", 64'(hi), 64'hFFFFFFFF);
    applyStimulus(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "div_wrap");
    checkOutput("div_wrap_lo_const", 64'(lo), 64'h80000000);
    checkOutput("div_wrap_hi_const", 64'(hi), 64'h00000000);

    // Divide by zero keeps a preloaded HI/LO.
    applyStimulus(1'b1, 1'b0, 32'h00001234, 32'h00005678, 0, "preload");
    applyStimulus(1'b0, 1'b1, 32'h00000055, 32'd0, 0, "div_zero");

    // Arbitration: both starts together -> multiply.
    applyStimulus(1'b1, 1'b1, 32'hFFFF0001, 32'h00012345, 0, "both_start");

    // div_start pulsed while a multiply is busy is ignored.
    applyStimulus(1'b1, 1'b0, 32'h0BADF00D, 32'hFFFFFF9C, 5, "div_while_busy");

    // Reset at cycle 10 of a multiply aborts it.
    @(negedge clk);
    a          = 32'd5;
    b          = 32'd9;
    mult_start = 1'b1;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_hi", 64'(hi), 64'd0);
    checkOutput("abort_lo", 64'(lo), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    doneSeen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) doneSeen = 1'b1;
    end
    checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
    modelHi = 32'd0;
    modelLo = 32'd0;
    applyStimulus(1'b1, 1'b0, 32'd12345, 32'hFFFFFD5A, 0, "after_abort");

    // Randomized multiplies.
    for (int i = 0; i < 8; i++) begin
      rA = $urandom;
      rB = $urandom;
      applyStimulus(1'b1, 1'b0, rA, rB, 0, "rand_mult");
    end

    // Randomized divides with a mix of divisor magnitudes.
    for (int i = 0; i < 10; i++) begin
      rA = $urandom;
      case (i % 4)
        0: rB = $urandom_range(1, 15);
        1: rB = 32'd0 - $urandom_range(1, 300);
        2: rB = $urandom;
        default: rB = (i == 7) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      applyStimulus(1'b0, 1'b1, rA, rB, 0, "rand_div");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
